barrel_shift_arb: RTL and testbench

Round-robin arbiter and issue stage that shares the single 32-bit `Barrel_shift_sel` datapath between `NREQ` requesters. It accepts one shift request per cycle over valid/ready handshakes and drives the shifter combinationally from the granted request. It registers the result with its requester ID into a one-entry output buffer, which drains over a valid/ready response channel. It sits between the client units and the shifter instance, which is instantiated inside this block.

---
 rtl/barrel_shift_arb.sv | 135 +++++++++++++
 tb/tb_barrel_shift_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_arb.sv
// Round-robin issue stage sharing one 32-bit logical shifter between NREQ requesters,
// with a one-entry output buffer. Define BSARB_PERF_EN for per-requester grant counters.

module barrel_shift_sel (
    input  logic [31:0] data,
    input  logic [4:0]  amnt,
    input  logic        lr,
    output logic [31:0] result
);
    // lr = 0 shifts toward the MSB, lr = 1 toward the LSB; zero fill both ways
    assign result = lr ? (data >> amnt) : (data << amnt);
endmodule

// state    | meaning
// ST_EMPTY | output buffer holds nothing, any pending request may be granted
// ST_FULL  | output buffer holds a result; a grant needs rsp_ready in the same cycle
module barrel_shift_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_amnt,
    input  logic [NREQ-1:0]      req_lr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
`ifdef BSARB_PERF_EN
    input  logic [IDW-1:0]       perf_sel,
    output logic [15:0]          perf_cnt,
`endif
    output logic [31:0]          rsp_data
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] ptr;
    logic           can_accept;
    logic           accept;
    logic           hit_hi, hit_lo;
    logic [IDW-1:0] gnt_hi, gnt_lo, gnt, ptr_next;
    logic [31:0]    sh_data, sh_result;
    logic [4:0]     sh_amnt;
    logic           sh_lr;

    assign can_accept = (state == ST_EMPTY) || rsp_ready;
    assign rsp_valid  = (state == ST_FULL);

    // Requesters at or above ptr win over those below it; lowest index wins within each half.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        gnt_hi = '0;
        gnt_lo = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    gnt_hi = IDW'(i);
                end else begin
                    hit_lo = 1'b1;
                    gnt_lo = IDW'(i);
                end
            end
        end
    end

    assign gnt       = hit_hi ? gnt_hi : gnt_lo;
    assign accept    = can_accept && (hit_hi || hit_lo);
    assign req_ready = accept ? (NREQ'(1) << gnt) : '0;
    assign ptr_next  = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);

    always_comb begin
        sh_data = '0;
        sh_amnt = '0;
        sh_lr   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sh_data = req_data[i*32 +: 32];
                sh_amnt = req_amnt[i*5 +: 5];
                sh_lr   = req_lr[i];
            end
        end
    end

    barrel_shift_sel u_shift (
        .data   (sh_data),
        .amnt   (sh_amnt),
        .lr     (sh_lr),
        .result (sh_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else if (accept) begin
            state    <= ST_FULL;
            ptr      <= ptr_next;
            rsp_id   <= gnt;
            rsp_data <= sh_result;
        end else if (state == ST_FULL && rsp_ready) begin
            state    <= ST_EMPTY;
        end
    end

`ifdef BSARB_PERF_EN
    logic [15:0] grant_cnt [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && gnt == IDW'(i) && grant_cnt[i] != 16'hFFFF)
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
        end
    end

    // Out-of-range selects match no counter and read as zero.
    always_comb begin
        perf_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (perf_sel == IDW'(i)) perf_cnt = grant_cnt[i];
        end
    end
`endif
endmodule

// File: tb/tb_barrel_shift_arb.sv
// Scoreboard bench for barrel_shift_arb: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every rsp_valid & rsp_ready.

module tb_barrel_shift_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [5*NREQ-1:0] req_amnt;
    logic [NREQ-1:0]   req_lr;
    logic [32*NREQ-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data;
`ifdef BSARB_PERF_EN
    logic [IDW-1:0]    perf_sel;
    logic [15:0]       perf_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [IDW+31:0] exp_q [$];

    localparam logic [31:0] OPND = 32'hD6975971;

    barrel_shift_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_amnt  (req_amnt),
        .req_lr    (req_lr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef BSARB_PERF_EN
        .perf_sel  (perf_sel),
        .perf_cnt  (perf_cnt),
`endif
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] amnt, input logic lr, input logic [31:0] data);
        req_amnt[i*5 +: 5]  = amnt;
        req_lr[i]           = lr;
        req_data[i*32 +: 32] = data;
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [31:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every consumed response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected actual=id%0d/%h required=none", rsp_id, rsp_data);
            end else begin
                logic [IDW+31:0] e;
                e = exp_q.pop_front();
                if (rsp_id !== e[IDW+31:32] || rsp_data !== e[31:0]) begin
                    failures++;
                    $display("FAIL rsp_match actual=id%0d/%h required=id%0d/%h",
                             rsp_id, rsp_data, e[IDW+31:32], e[31:0]);
                end
            end
        end
    end

    logic [31:0] r_exp [4];
    logic [4:0]  r_amt [4];
    logic [NREQ-1:0] fair_gnt [4];

    initial begin
        r_amt[0] = 5'd2;  r_exp[0] = 32'h35A5D65C;
        r_amt[1] = 5'd3;  r_exp[1] = 32'h1AD2EB2E;
        r_amt[2] = 5'd5;  r_exp[2] = 32'h06B4BACB;
        r_amt[3] = 5'd10; r_exp[3] = 32'h0035A5D6;
        fair_gnt[0] = 4'b0001; fair_gnt[1] = 4'b0100;
        fair_gnt[2] = 4'b0001; fair_gnt[3] = 4'b0100;

        req_amnt = '0;
        req_lr   = '0;
        req_data = '0;
`ifdef BSARB_PERF_EN
        perf_sel = '0;
`endif
        do_reset();

        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(rsp_id),    32'd0);
        chk("reset_rsp_data",  rsp_data,       32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);

        // Single left shift
        step();
        set_req(0, 5'd4, 1'b0, OPND);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        push(3'd0, 32'h69759710);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_latency", 32'(rsp_valid), 32'd1);
        step();

        // Four right shifts, consecutive grants 0..3
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, r_amt[i], 1'b1, OPND);
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(4'b0001 << k));
            push(3'(k), r_exp[k]);
            step();
            req_valid[k] = 1'b0;
        end
        step();

        // Backpressure with req1 pending; drain and accept together on release
        set_req(0, 5'd1, 1'b0, OPND);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_grant", 32'(req_ready), 32'h1);
        push(3'd0, 32'hAD2EB2E2);
        step();
        set_req(1, 5'd31, 1'b0, OPND);
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready",     32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id",    32'(rsp_id),    32'd0);
            chk("bp_rsp_data",  rsp_data,       32'hAD2EB2E2);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'h2);
        push(3'd1, 32'h80000000);
        step();

        // req3, right by 0; pointer was left at 2 so req3 is next
        set_req(3, 5'd0, 1'b1, OPND);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("edge_r0_grant", 32'(req_ready), 32'h8);
        push(3'd3, OPND);
        step();

        // Fairness: req0 and req2 held; pointer wraps 3 -> 0 between grants
        set_req(0, 5'd0, 1'b0, OPND);
        set_req(2, 5'd31, 1'b1, OPND);
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("fair_grant%0d", k), 32'(req_ready), 32'(fair_gnt[k]));
            if (fair_gnt[k] == 4'b0001) push(3'd0, OPND);
            else                        push(3'd2, 32'h00000001);
            step();
        end
        req_valid = '0;
        step();

`ifdef BSARB_PERF_EN
        perf_sel = 3'd2;
        #1 chk("perf_req2", 32'(perf_cnt), 32'd3);
        perf_sel = 3'd0;
        #1 chk("perf_req0", 32'(perf_cnt), 32'd4);
        perf_sel = 3'd5;
        #1 chk("perf_out_of_range", 32'(perf_cnt), 32'd0);
`endif

        // Reset while FULL drops the held result without a handshake
        set_req(1, 5'd4, 1'b0, OPND);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_pre_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        #1 chk("rst_pre_full", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 32'd0);
        chk("rst_async_id",    32'(rsp_id),    32'd0);
        chk("rst_async_data",  rsp_data,       32'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
`ifdef BSARB_PERF_EN
        perf_sel = 3'd2;
        #1 chk("perf_after_reset", 32'(perf_cnt), 32'd0);
`endif
        // ptr back at 0: req1 must win over req2
        req_valid = 4'b0110;
        @(negedge clk);
        chk("rst_ptr_zero", 32'(req_ready), 32'h2);
        push(3'd1, 32'h69759710);
        step();
        req_valid = '0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
